// File: rtl/pontos_pkg.sv
// Shared types and helpers for the Simon-style score engine.
// Holds the request FSM encoding and a saturating add used on the score path.
package pontos_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        BUSCA  = 2'd1,
        SOMA   = 2'd2,
        FIM    = 2'd3
    } estado_t;

    // Operands are zero-extended to 32 bits by the caller; returns min(a+b, lim).
    function automatic logic [31:0] soma_sat(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, lim})
            return lim;
        return s[31:0];
    endfunction

endpackage

// File: rtl/tabela_pontos.sv
// Purpose: base points per round (round 0 -> 1, capped at BASE_MAX).
// Latency: combinational, zero cycles.
// Backpressure: none, pure lookup.
module tabela_pontos #(
    parameter int W_RODADA = 4,
    parameter int W_PONTOS = 8,
    parameter int BASE_MAX = 9
) (
    input  logic [W_RODADA-1:0] rodada,
    output logic [W_PONTOS-1:0] base
);

    always_comb begin
        base = W_PONTOS'(rodada);
        if (rodada == '0)
            base = W_PONTOS'(1);
        else if (32'(rodada) > 32'(BASE_MAX))
            base = W_PONTOS'(BASE_MAX);
    end

endmodule

// File: rtl/acumulador_pontos.sv
// Purpose: per-player score accumulator with error penalty and perfect-round streak bonus.
// Latency: accept edge k -> done pulse in cycle k+3; one request in flight at a time.
// Backpressure: calc_ready low outside OCIOSO and while limpar is asserted.
module acumulador_pontos
    import pontos_pkg::*;
#(
    parameter int N_JOGADORES = 2,
    parameter int W_PONTOS    = 8,
    parameter int W_RODADA    = 4,
    parameter int W_ERROS     = 8,
    parameter int BASE_MAX    = 9,
    parameter int MAX_SEQ     = 3,
    localparam int W_JOG      = (N_JOGADORES > 1) ? $clog2(N_JOGADORES) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                limpar,
    input  logic                calc_valid,
    output logic                calc_ready,
    input  logic [W_JOG-1:0]    jogador,
    input  logic [W_RODADA-1:0] rodada,
    input  logic [W_ERROS-1:0]  erros,
    output logic                done,
    output logic [W_PONTOS-1:0] pontos_rodada,
    output logic [W_PONTOS-1:0] pontos_out,
    output logic                saturou,
    input  logic [W_JOG-1:0]    sel_leitura,
    output logic [W_PONTOS-1:0] pontos_leitura
);

    localparam int W_SEQ = (MAX_SEQ > 0) ? $clog2(MAX_SEQ + 1) : 1;
    localparam int W_EXT = W_PONTOS + 2;
    localparam logic [W_PONTOS-1:0] PONTOS_MAX = '1;

    estado_t estado_q, estado_d;

    logic [W_JOG-1:0]    jog_q;
    logic [W_RODADA-1:0] rod_q;
    logic [W_ERROS-1:0]  err_q;
    logic [W_PONTOS-1:0] base, base_q;

    logic [W_PONTOS-1:0] placar [N_JOGADORES];
    logic [W_SEQ-1:0]    seq    [N_JOGADORES];

    logic                aceita;
    logic                jog_ok;
    logic [W_JOG-1:0]    jog_idx;
    logic [W_PONTOS-1:0] placar_atual;
    logic [W_SEQ-1:0]    seq_atual;
    logic [W_SEQ-1:0]    seq_prox;
    logic [W_PONTOS-1:0] delta;
    logic [W_EXT-1:0]    pts_ext;
    logic [W_EXT-1:0]    total_ext;
    logic                sat;
    logic [W_PONTOS-1:0] novo_placar;
    logic [W_PONTOS-1:0] novo_pts;

    tabela_pontos #(
        .W_RODADA (W_RODADA),
        .W_PONTOS (W_PONTOS),
        .BASE_MAX (BASE_MAX)
    ) u_tabela (
        .rodada (rod_q),
        .base   (base)
    );

    assign calc_ready = (estado_q == OCIOSO) && !limpar;
    assign aceita     = calc_valid && calc_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            estado_q <= OCIOSO;
        else
            estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:  if (aceita) estado_d = BUSCA;
            BUSCA:   estado_d = SOMA;
            SOMA:    estado_d = FIM;
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
        if (limpar)
            estado_d = OCIOSO;
    end

    // Out-of-range players are steered to index 0 for the reads; writes are gated by jog_ok.
    assign jog_ok       = 32'(jog_q) < 32'(N_JOGADORES);
    assign jog_idx      = jog_ok ? jog_q : '0;
    assign placar_atual = placar[jog_idx];
    assign seq_atual    = seq[jog_idx];

    always_comb begin
        delta = '0;
        if (32'(base_q) > 32'(err_q))
            delta = base_q - W_PONTOS'(err_q);

        seq_prox = '0;
        if (err_q == '0) begin
            if (32'(seq_atual) >= 32'(MAX_SEQ))
                seq_prox = W_SEQ'(MAX_SEQ);
            else
                seq_prox = seq_atual + 1'b1;
        end

        // Bonus equals the updated streak, which is already zero on imperfect rounds.
        pts_ext     = W_EXT'(delta) + W_EXT'(seq_prox);
        total_ext   = W_EXT'(placar_atual) + pts_ext;
        sat         = total_ext > W_EXT'(PONTOS_MAX);
        novo_placar = W_PONTOS'(soma_sat(32'(placar_atual), 32'(pts_ext), 32'(PONTOS_MAX)));
        novo_pts    = W_PONTOS'(soma_sat(32'(pts_ext), 32'd0, 32'(PONTOS_MAX)));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jog_q         <= '0;
            rod_q         <= '0;
            err_q         <= '0;
            base_q        <= '0;
            done          <= 1'b0;
            saturou       <= 1'b0;
            pontos_rodada <= '0;
            pontos_out    <= '0;
            for (int i = 0; i < N_JOGADORES; i++) begin
                placar[i] <= '0;
                seq[i]    <= '0;
            end
        end else if (limpar) begin
            done          <= 1'b0;
            saturou       <= 1'b0;
            pontos_rodada <= '0;
            pontos_out    <= '0;
            for (int i = 0; i < N_JOGADORES; i++) begin
                placar[i] <= '0;
                seq[i]    <= '0;
            end
        end else begin
            done <= (estado_q == SOMA);
            if (aceita) begin
                jog_q <= jogador;
                rod_q <= rodada;
                err_q <= erros;
            end
            if (estado_q == BUSCA)
                base_q <= base;
            if (estado_q == SOMA) begin
                if (jog_ok) begin
                    placar[jog_idx] <= novo_placar;
                    seq[jog_idx]    <= seq_prox;
                    pontos_rodada   <= novo_pts;
                    pontos_out      <= novo_placar;
                    saturou         <= sat;
                end else begin
                    pontos_rodada <= '0;
                    pontos_out    <= '0;
                    saturou       <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        pontos_leitura = '0;
        if (32'(sel_leitura) < 32'(N_JOGADORES))
            pontos_leitura = placar[sel_leitura];
    end

endmodule

// File: tb/tb_acumulador_pontos.sv
// Self-checking bench for acumulador_pontos: vector table, scoreboard queue and corner sequences.
module tb_acumulador_pontos;

    typedef struct {
        int pts;
        int tot;
        int sat;
    } exp_t;

    typedef struct {
        int   j;
        int   r;
        int   e;
        exp_t ex;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       limpar = 1'b0;
    logic       calc_valid = 1'b0;
    logic       calc_ready;
    logic [1:0] jogador = '0;
    logic [3:0] rodada = '0;
    logic [7:0] erros = '0;
    logic       done;
    logic [7:0] pontos_rodada;
    logic [7:0] pontos_out;
    logic       saturou;
    logic [1:0] sel_leitura = '0;
    logic [7:0] pontos_leitura;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    int   m_placar[4];
    int   m_seq[4];

    acumulador_pontos #(
        .N_JOGADORES (3),
        .W_PONTOS    (8),
        .W_RODADA    (4),
        .W_ERROS     (8),
        .BASE_MAX    (9),
        .MAX_SEQ     (3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .limpar         (limpar),
        .calc_valid     (calc_valid),
        .calc_ready     (calc_ready),
        .jogador        (jogador),
        .rodada         (rodada),
        .erros          (erros),
        .done           (done),
        .pontos_rodada  (pontos_rodada),
        .pontos_out     (pontos_out),
        .saturou        (saturou),
        .sel_leitura    (sel_leitura),
        .pontos_leitura (pontos_leitura)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
        end
    endtask

    // Reference model: base table, floored penalty, capped streak bonus, saturating total.
    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_placar[i] = 0;
            m_seq[i]    = 0;
        end
    endtask

    task automatic model(input int j, input int r, input int e, output exp_t x);
        int base, delta, sq, p, tot;
        base  = (r == 0) ? 1 : ((r > 9) ? 9 : r);
        delta = (base > e) ? base - e : 0;
        x = '{0, 0, 0};
        if (j >= 3)
            return;
        sq  = (e == 0) ? ((m_seq[j] + 1 > 3) ? 3 : m_seq[j] + 1) : 0;
        p   = delta + sq;
        tot = m_placar[j] + p;
        x.sat = (tot > 255) ? 1 : 0;
        x.tot = (tot > 255) ? 255 : tot;
        x.pts = (p > 255) ? 255 : p;
        m_placar[j] = x.tot;
        m_seq[j]    = sq;
    endtask

    always @(negedge clock) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending request at %0t", $time);
            end else begin
                exp_t ex;
                ex = sb.pop_front();
                check("pontos_rodada", int'(pontos_rodada), ex.pts);
                check("pontos_out", int'(pontos_out), ex.tot);
                check("saturou", int'(saturou), ex.sat);
            end
        end
    end

    task automatic req(input int j, input int r, input int e, input exp_t ex, input bit chk_ready);
        bit got;
        int lat;
        @(posedge clock);
        #1;
        jogador    = 2'(j);
        rodada     = 4'(r);
        erros      = 8'(e);
        calc_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (calc_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("accept_timeout", 0, 1);
            calc_valid = 1'b0;
            return;
        end
        @(posedge clock);
        sb.push_back(ex);
        #1 calc_valid = 1'b0;
        got = 1'b0;
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (chk_ready && i <= 3)
                check("ready_busy", int'(calc_ready), 0);
            if (done) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
        check("latency", lat, 3);
        if (chk_ready) begin
            @(negedge clock);
            check("ready_back", int'(calc_ready), 1);
            check("done_one_cycle", int'(done), 0);
            check("pontos_out_hold", int'(pontos_out), ex.tot);
        end
    endtask

    task automatic ler(input string nome, input int j, input int exp);
        sel_leitura = 2'(j);
        #1;
        check(nome, int'(pontos_leitura), exp);
    endtask

    initial begin
        vec_t tabela[9];
        exp_t ex;
        exp_t dummy;
        int   ndone;

        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tabela[9];
        exp_t ex;
        exp_t dummy;
        int   ndone;

        tabela[0] = '{0, 5, 2, '{3, 3, 0}};
        tabela[1] = '{0, 3, 7, '{0, 3, 0}};
        tabela[2] = '{0, 1, 0, '{2, 5, 0}};
        tabela[3] = '{1, 2, 0, '{3, 3, 0}};
        tabela[4] = '{1, 2, 0, '{4, 7, 0}};
        tabela[5] = '{1, 2, 0, '{5, 12, 0}};
        tabela[6] = '{1, 2, 0, '{5, 17, 0}};
        tabela[7] = '{1, 2, 1, '{1, 18, 0}};
        tabela[8] = '{1, 2, 0, '{3, 21, 0}};

        model_clear();
        #3;
        check("rst_done", int'(done), 0);
        check("rst_pontos_out", int'(pontos_out), 0);
        check("rst_pontos_rodada", int'(pontos_rodada), 0);
        check("rst_saturou", int'(saturou), 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_ready", int'(calc_ready), 1);
        ler("rst_leitura_p0", 0, 0);
        ler("rst_leitura_p1", 1, 0);

        for (int i = 0; i < 9; i++) begin
            model(tabela[i].j, tabela[i].r, tabela[i].e, dummy);
            req(tabela[i].j, tabela[i].r, tabela[i].e, tabela[i].ex, (i == 0));
        end
        ler("tab_leitura_p0", 0, 5);
        ler("tab_leitura_p1", 1, 21);

        // Asynchronous reset while the request sits in SOMA.
        @(posedge clock);
        #1;
        jogador = 2'd1; rodada = 4'd9; erros = 8'd0; calc_valid = 1'b1;
        @(posedge clock);
        #1 calc_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_done", int'(done), 0);
        check("arst_pontos_out", int'(pontos_out), 0);
        check("arst_pontos_rodada", int'(pontos_rodada), 0);
        ler("arst_leitura_p1", 1, 0);
        @(negedge clock);
        reset = 1'b1;
        model_clear();
        #1;
        check("arst_ready", int'(calc_ready), 1);
        ler("arst_leitura_p0", 0, 0);
        ler("arst_leitura_p1b", 1, 0);

        // Build player 0 up to 250 with imperfect rounds, then overflow it.
        for (int i = 0; i < 31; i++) begin
            model(0, 9, 1, ex);
            req(0, 9, 1, ex, 1'b0);
        end
        model(0, 3, 1, ex);
        req(0, 3, 1, ex, 1'b0);
        ler("pre_sat_leitura", 0, 250);
        model(0, 12, 0, dummy);
        req(0, 12, 0, '{10, 255, 1}, 1'b1);
        ler("sat_leitura", 0, 255);

        // limpar during BUSCA with a new calc_valid on the same edge.
        @(posedge clock);
        #1;
        jogador = 2'd0; rodada = 4'd4; erros = 8'd0; calc_valid = 1'b1;
        @(posedge clock);
        #1;
        jogador = 2'd1; rodada = 4'd2;
        @(negedge clock);
        limpar = 1'b1;
        #1;
        check("limpar_ready", int'(calc_ready), 0);
        @(posedge clock);
        #1;
        limpar = 1'b0;
        calc_valid = 1'b0;
        model_clear();
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done)
                ndone++;
        end
        check("limpar_no_done", ndone, 0);
        check("limpar_pontos_out", int'(pontos_out), 0);
        check("limpar_saturou", int'(saturou), 0);
        check("limpar_ready_back", int'(calc_ready), 1);
        ler("limpar_leitura_p0", 0, 0);

        // Out-of-range player: done pulses, no state changes (streak of player 0 survives).
        model(0, 4, 0, dummy);
        req(0, 4, 0, '{5, 5, 0}, 1'b0);
        model(3, 5, 0, dummy);
        req(3, 5, 0, '{0, 0, 0}, 1'b0);
        model(0, 4, 0, dummy);
        req(0, 4, 0, '{6, 11, 0}, 1'b0);
        ler("oor_leitura_p0", 0, 11);
        ler("oor_leitura_p1", 1, 0);
        ler("oor_leitura_p2", 2, 0);
        ler("oor_leitura_sel3", 3, 0);

        repeat (4) @(negedge clock);
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
